// File: rtl/keccak_round_sequencer.sv
// Round/slice sequencer for slice-serial DOM-masked Keccak-f: rho/pi lane phase then slice phase per round.
// Done 1+ROUNDS*(RHOPI_CYCLES+NS*CYCLES_PER_SLICE) cycles after Start; slice phase stalls while RandValidxSI is low.
module keccak_round_sequencer #(
    parameter int W                = 16,
    parameter int COUNTER_BITWIDTH = 4,
    parameter int SLICES_PARALLEL  = 1,
    parameter int ROUNDS           = 20,
    parameter int RHOPI_CYCLES     = 25,
    parameter int CYCLES_PER_SLICE = 2
) (
    input  logic                        ClkxCI,
    input  logic                        RstxRBI,
    input  logic                        StartxSI,
    input  logic                        AbortxSI,
    input  logic                        RandValidxSI,
    output logic [4:0]                  RoundNrxDO,
    output logic [COUNTER_BITWIDTH:0]   SliceNrxDO,
    output logic [COUNTER_BITWIDTH:0]   NextSliceNrxDO,
    output logic                        ResetRCxSO,
    output logic                        EnableRCxSO,
    output logic                        RhoPiEnxSO,
    output logic                        SliceEnxSO,
    output logic                        RandReqxSO,
    output logic                        BusyxSO,
    output logic                        DonexSO
);

    localparam int NS = W / SLICES_PARALLEL;
    localparam int CW = COUNTER_BITWIDTH + 1;
    localparam int PW = (RHOPI_CYCLES > 1) ? $clog2(RHOPI_CYCLES) : 1;

    localparam logic [CW-1:0] LAST_SLICE = CW'(NS - 1);
    localparam logic [PW-1:0] LAST_PHASE = PW'(RHOPI_CYCLES - 1);
    localparam logic [0:0]    LAST_SUB   = 1'(CYCLES_PER_SLICE - 1);
    localparam logic [4:0]    LAST_ROUND = 5'(ROUNDS - 1);

    typedef enum logic [1:0] {
        IDLE,
        RHOPI,
        SLICE,
        DONE
    } state_e;

    state_e        state_q, state_d;
    logic [4:0]    round_q, round_d;
    logic [CW-1:0] slice_q, slice_d;
    logic [0:0]    sub_q, sub_d;
    logic [PW-1:0] phase_q, phase_d;
    logic [CW-1:0] next_slice;

    always_ff @(posedge ClkxCI or negedge RstxRBI) begin
        if (!RstxRBI) begin
            state_q <= IDLE;
            round_q <= '0;
            slice_q <= '0;
            sub_q   <= '0;
            phase_q <= '0;
        end else begin
            state_q <= state_d;
            round_q <= round_d;
            slice_q <= slice_d;
            sub_q   <= sub_d;
            phase_q <= phase_d;
        end
    end

    assign next_slice = (slice_q == LAST_SLICE) ? '0 : slice_q + 1'b1;

    always_comb begin
        state_d     = state_q;
        round_d     = round_q;
        slice_d     = slice_q;
        sub_d       = sub_q;
        phase_d     = phase_q;
        ResetRCxSO  = 1'b0;
        EnableRCxSO = 1'b0;
        RhoPiEnxSO  = 1'b0;
        SliceEnxSO  = 1'b0;
        RandReqxSO  = 1'b0;
        DonexSO     = 1'b0;

        case (state_q)
            IDLE: begin
                if (StartxSI) begin
                    state_d    = RHOPI;
                    round_d    = '0;
                    phase_d    = '0;
                    ResetRCxSO = 1'b1;
                end
            end
            RHOPI: begin
                RhoPiEnxSO = 1'b1;
                phase_d    = phase_q + 1'b1;
                if (phase_q == LAST_PHASE) begin
                    state_d = SLICE;
                    slice_d = '0;
                    sub_d   = '0;
                end
            end
            SLICE: begin
                SliceEnxSO  = RandValidxSI;
                EnableRCxSO = RandValidxSI;
                RandReqxSO  = RandValidxSI;
                // Without fresh randomness every counter freezes.
                if (RandValidxSI) begin
                    if (sub_q == LAST_SUB) begin
                        sub_d   = '0;
                        slice_d = next_slice;
                        if (slice_q == LAST_SLICE) begin
                            if (round_q == LAST_ROUND) begin
                                state_d = DONE;
                            end else begin
                                round_d = round_q + 5'd1;
                                phase_d = '0;
                                state_d = RHOPI;
                            end
                        end
                    end else begin
                        sub_d = sub_q + 1'b1;
                    end
                end
            end
            DONE: begin
                DonexSO = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (AbortxSI) begin
            state_d    = IDLE;
            round_d    = '0;
            slice_d    = '0;
            sub_d      = '0;
            phase_d    = '0;
            ResetRCxSO = 1'b0;
            DonexSO    = 1'b0;
        end
    end

    assign RoundNrxDO     = round_q;
    assign SliceNrxDO     = slice_q;
    assign NextSliceNrxDO = next_slice;
    assign BusyxSO        = (state_q != IDLE);

endmodule

// File: tb/tb_keccak_round_sequencer.sv
// Directed bench for keccak_round_sequencer: default instance plus a W=64 single-cycle-slice instance.
// Expected Done cycles and per-run enable counts are queued at Start and checked when Done appears.
module tb_keccak_round_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    logic start, abort, rv;
    logic startb, rvb;

    logic [4:0] round_a, round_b;
    logic [4:0] slice_a, next_a;
    logic [6:0] slice_b, next_b;
    logic rrc_a, erc_a, rp_a, se_a, rq_a, busy_a, done_a;
    logic rrc_b, erc_b, rp_b, se_b, rq_b, busy_b, done_b;

    keccak_round_sequencer dut_a (
        .ClkxCI(clk), .RstxRBI(rst_n), .StartxSI(start), .AbortxSI(abort),
        .RandValidxSI(rv), .RoundNrxDO(round_a), .SliceNrxDO(slice_a),
        .NextSliceNrxDO(next_a), .ResetRCxSO(rrc_a), .EnableRCxSO(erc_a),
        .RhoPiEnxSO(rp_a), .SliceEnxSO(se_a), .RandReqxSO(rq_a),
        .BusyxSO(busy_a), .DonexSO(done_a)
    );

    keccak_round_sequencer #(
        .W(64), .COUNTER_BITWIDTH(6), .SLICES_PARALLEL(1), .ROUNDS(24),
        .RHOPI_CYCLES(25), .CYCLES_PER_SLICE(1)
    ) dut_b (
        .ClkxCI(clk), .RstxRBI(rst_n), .StartxSI(startb), .AbortxSI(1'b0),
        .RandValidxSI(rvb), .RoundNrxDO(round_b), .SliceNrxDO(slice_b),
        .NextSliceNrxDO(next_b), .ResetRCxSO(rrc_b), .EnableRCxSO(erc_b),
        .RhoPiEnxSO(rp_b), .SliceEnxSO(se_b), .RandReqxSO(rq_b),
        .BusyxSO(busy_b), .DonexSO(done_b)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    typedef struct {
        int done_cyc;
        int rp;
        int sl;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    int rpa = 0, sla = 0, rpb = 0, slb = 0;

    // Scoreboard for instance A
    always @(negedge clk) begin
        exp_t e;
        #2;
        if (rrc_a) begin rpa = 0; sla = 0; end
        if (rp_a) rpa++;
        if (se_a) sla++;
        if (done_a) begin
            if (qa.size() == 0) begin
                chk("done_without_start_a", qa.size(), 1);
            end else begin
                e = qa.pop_front();
                chk("done_cycle_a", cyc, e.done_cyc);
                chk("rhopi_cycles_a", rpa, e.rp);
                chk("slice_cycles_a", sla, e.sl);
            end
        end
    end

    // Scoreboard for instance B
    always @(negedge clk) begin
        exp_t e;
        #2;
        if (rrc_b) begin rpb = 0; slb = 0; end
        if (rp_b) rpb++;
        if (se_b) slb++;
        if (done_b) begin
            if (qb.size() == 0) begin
                chk("done_without_start_b", qb.size(), 1);
            end else begin
                e = qb.pop_front();
                chk("done_cycle_b", cyc, e.done_cyc);
                chk("rhopi_cycles_b", rpb, e.rp);
                chk("slice_cycles_b", slb, e.sl);
            end
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic start_a(input int stall, output int s);
        exp_t e;
        tick();
        start = 1'b1;
        s = cyc;
        e.done_cyc = s + 1141 + stall;
        e.rp = 500;
        e.sl = 640;
        qa.push_back(e);
        #1;
        chk("resetrc_on_start", rrc_a, 1);
        tick();
        start = 1'b0;
        #1;
        chk("resetrc_one_cycle", rrc_a, 0);
        chk("busy_after_start", busy_a, 1);
    endtask

    task automatic wait_done_a(input string tag);
        int n = 0;
        do begin tick(); #1; n++; end while (!done_a && n < 2000);
        chk(tag, done_a, 1);
    endtask

    initial begin
        int s, n;
        exp_t eb;
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; rv = 1'b1;
        startb = 1'b0; rvb = 1'b1;

        // 1: reset state
        tick(); tick(); #1;
        chk("rst_busy", busy_a, 0);
        chk("rst_done", done_a, 0);
        chk("rst_resetrc", rrc_a, 0);
        chk("rst_rhopien", rp_a, 0);
        chk("rst_sliceen", se_a, 0);
        chk("rst_enablerc", erc_a, 0);
        chk("rst_randreq", rq_a, 0);
        chk("rst_round", round_a, 0);
        chk("rst_slice", slice_a, 0);
        chk("rst_nextslice", next_a, 1);
        tick(); rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick(); #1;
            chk("idle_no_start_busy", busy_a, 0);
        end

        // 2: nominal run
        start_a(0, s);
        chk("rhopi_first_round", rp_a, 1);
        chk("round_first", round_a, 0);
        n = 0;
        do begin tick(); #1; n++; end while (!se_a && n < 100);
        chk("first_slice_cycle", cyc, s + 26);
        n = 0;
        do begin tick(); #1; n++; end while (!(se_a && slice_a == 15) && n < 100);
        chk("nextslice_wrap", next_a, 0);
        n = 0;
        do begin tick(); #1; n++; end while (!rp_a && n < 100);
        chk("second_round_nr", round_a, 1);
        wait_done_a("done_seen_nominal");
        chk("final_round", round_a, 19);
        tick(); #1;
        chk("busy_after_done", busy_a, 0);
        chk("done_one_cycle", done_a, 0);

        // 3: randomness stall at round 3 slice 7 subcycle 1
        start_a(5, s);
        n = 0;
        do begin tick(); #1; n++; end while (!(se_a && round_a == 3 && slice_a == 7) && n < 500);
        chk("reach_r3_s7", slice_a, 7);
        for (int i = 0; i < 5; i++) begin
            tick(); rv = 1'b0; #1;
            chk("stall_sliceen", se_a, 0);
            chk("stall_enablerc", erc_a, 0);
            chk("stall_randreq", rq_a, 0);
            chk("stall_slice", slice_a, 7);
            chk("stall_round", round_a, 3);
        end
        tick(); rv = 1'b1; #1;
        chk("resume_slice", slice_a, 7);
        chk("resume_sliceen", se_a, 1);
        tick(); #1;
        chk("resume_advance", slice_a, 8);
        wait_done_a("done_seen_stall");

        // 4: abort mid-slice in round 5
        start_a(0, s);
        n = 0;
        do begin tick(); #1; n++; end while (!(se_a && round_a == 5 && slice_a == 10) && n < 800);
        chk("reach_r5", round_a, 5);
        tick(); abort = 1'b1; qa.delete(); #1;
        tick(); abort = 1'b0; #1;
        chk("abort_busy", busy_a, 0);
        chk("abort_round", round_a, 0);
        chk("abort_slice", slice_a, 0);
        chk("abort_nextslice", next_a, 1);
        for (int i = 0; i < 20; i++) tick();
        #1;
        chk("abort_stays_idle", busy_a, 0);
        tick(); start = 1'b1; abort = 1'b1; #1;
        chk("abort_blocks_resetrc", rrc_a, 0);
        tick(); start = 1'b0; abort = 1'b0; #1;
        chk("abort_blocks_start", busy_a, 0);
        start_a(0, s);
        wait_done_a("done_seen_after_abort");

        // 6: Start ignored while busy, async reset mid-slice
        start_a(0, s);
        n = 0;
        do begin tick(); #1; n++; end while (!(rp_a && round_a == 2) && n < 500);
        tick(); start = 1'b1; #1;
        chk("restart_rhopi_resetrc", rrc_a, 0);
        tick(); start = 1'b0;
        n = 0;
        do begin tick(); #1; n++; end while (!(se_a && round_a == 4) && n < 500);
        tick(); start = 1'b1; #1;
        chk("restart_slice_resetrc", rrc_a, 0);
        tick(); start = 1'b0;
        wait_done_a("done_seen_restart");
        start = 1'b1;
        #1;
        chk("restart_done_resetrc", rrc_a, 0);
        tick(); start = 1'b0; #1;
        chk("restart_done_idle", busy_a, 0);
        tick(); #1;
        chk("restart_done_not_queued", busy_a, 0);
        start_a(0, s);
        n = 0;
        do begin tick(); #1; n++; end while (!(se_a && round_a == 1) && n < 500);
        tick(); rst_n = 1'b0; qa.delete(); #1;
        chk("midrun_reset_busy", busy_a, 0);
        chk("midrun_reset_round", round_a, 0);
        chk("midrun_reset_sliceen", se_a, 0);
        tick(); rst_n = 1'b1;
        for (int i = 0; i < 20; i++) tick();
        #1;
        chk("midrun_reset_idle", busy_a, 0);

        // 5: W=64, single-cycle slices, 24 rounds
        tick(); startb = 1'b1; s = cyc;
        eb.done_cyc = s + 2137; eb.rp = 600; eb.sl = 1536;
        qb.push_back(eb);
        tick(); startb = 1'b0;
        n = 0;
        do begin tick(); #1; n++; end while (!(se_b && slice_b == 63) && n < 300);
        chk("b_last_slice", slice_b, 63);
        chk("b_nextslice_wrap", next_b, 0);
        n = 0;
        do begin tick(); #1; n++; end while (!done_b && n < 2500);
        chk("b_done_seen", done_b, 1);
        chk("b_final_round", round_b, 23);

        tick(); tick(); #3;
        chk("pending_a", qa.size(), 0);
        chk("pending_b", qb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
